// File: rtl/game_pkg.sv
// Shared screen constants, sprite sizes and cannon state type for the game datapath.
package game_pkg;

    localparam int SCREEN_H    = 480;
    localparam int LASER_Y_MIN = 8;

    localparam int SHIP_W  = 30;
    localparam int ENEMY_W = 16;
    localparam int ENEMY_H = 16;
    localparam int LASER_W = 2;
    localparam int LASER_H = 8;

    typedef enum logic [1:0] {
        IDLE,
        FLIGHT,
        COOLDOWN
    } cannon_state_t;

endpackage

// File: rtl/aabb_overlap.sv
// Inclusive axis-aligned box overlap test, purely combinational (zero latency).
// No flow control; 11-bit operands keep the far edges from wrapping.
module aabb_overlap #(
    parameter int A_W = 2,
    parameter int A_H = 8,
    parameter int B_W = 16,
    parameter int B_H = 16
) (
    input  logic [10:0] ax,
    input  logic [10:0] ay,
    input  logic [10:0] bx,
    input  logic [10:0] by,
    output logic        overlap
);

    assign overlap = (ax <= bx + 11'(B_W - 1)) &&
                     (bx <= ax + 11'(A_W - 1)) &&
                     (ay <= by + 11'(B_H - 1)) &&
                     (by <= ay + 11'(A_H - 1));

endmodule

// File: rtl/player_cannon.sv
// Player laser cannon: launch on fire edge, step once per frame, hit-test all enemies.
// All outputs registered (one frame latency); no flow control, extra fire edges are dropped.
module player_cannon
    import game_pkg::*;
#(
    parameter int N_ENEMY         = 4,
    parameter int LASER_SPEED     = 8,
    parameter int COOLDOWN_FRAMES = 15
) (
    input  logic                   frame_clk,
    input  logic                   Reset,
    input  logic                   fire,
    input  logic [9:0]             PSX,
    input  logic [9:0]             PSY,
    input  logic [10*N_ENEMY-1:0]  EX_all,
    input  logic [10*N_ENEMY-1:0]  EY_all,
    input  logic [N_ENEMY-1:0]     enemy_alive,
    output logic [9:0]             laserX,
    output logic [9:0]             laserY,
    output logic                   laserexists,
    output logic [N_ENEMY-1:0]     Ehit,
    output logic                   score_inc
);

    localparam int CW = $clog2(COOLDOWN_FRAMES + 1);

    cannon_state_t      state, state_nxt;
    logic [CW-1:0]      count, count_nxt;
    logic               fire_prev;
    logic               fire_edge;
    logic [9:0]         x_nxt, y_nxt, launch_x, launch_y;
    logic               exists_nxt;
    logic [N_ENEMY-1:0] ehit_nxt, overlap, hits, first_hit;

    for (genvar i = 0; i < N_ENEMY; i++) begin : g_enemy
        aabb_overlap #(
            .A_W(LASER_W), .A_H(LASER_H), .B_W(ENEMY_W), .B_H(ENEMY_H)
        ) u_box (
            .ax     ({1'b0, laserX}),
            .ay     ({1'b0, laserY}),
            .bx     ({1'b0, EX_all[10*i +: 10]}),
            .by     ({1'b0, EY_all[10*i +: 10]}),
            .overlap(overlap[i])
        );
    end

    assign hits      = overlap & enemy_alive;
    // Isolate the lowest set bit so the lowest-indexed enemy wins a tie.
    assign first_hit = hits & (~hits + N_ENEMY'(1));
    assign fire_edge = fire & ~fire_prev;

    assign launch_x = PSX + 10'(SHIP_W / 2 - LASER_W / 2);
    assign launch_y = (PSY < 10'(LASER_H + LASER_Y_MIN)) ? 10'(LASER_Y_MIN)
                                                         : PSY - 10'(LASER_H);

    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        x_nxt      = laserX;
        y_nxt      = laserY;
        exists_nxt = laserexists;
        ehit_nxt   = '0;
        case (state)
            IDLE: begin
                if (fire_edge) begin
                    exists_nxt = 1'b1;
                    x_nxt      = launch_x;
                    y_nxt      = launch_y;
                    state_nxt  = FLIGHT;
                end
            end
            FLIGHT: begin
                if (|hits || laserY < 10'(LASER_Y_MIN + LASER_SPEED)) begin
                    ehit_nxt   = first_hit;
                    exists_nxt = 1'b0;
                    x_nxt      = '0;
                    y_nxt      = '0;
                    count_nxt  = CW'(COOLDOWN_FRAMES - 1);
                    state_nxt  = COOLDOWN;
                end else begin
                    y_nxt = laserY - 10'(LASER_SPEED);
                end
            end
            COOLDOWN: begin
                if (count == '0) begin
                    state_nxt = IDLE;
                end else begin
                    count_nxt = count - CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            count       <= '0;
            fire_prev   <= 1'b1;
            laserX      <= '0;
            laserY      <= '0;
            laserexists <= 1'b0;
            Ehit        <= '0;
            score_inc   <= 1'b0;
        end else begin
            state       <= state_nxt;
            count       <= count_nxt;
            fire_prev   <= fire;
            laserX      <= x_nxt;
            laserY      <= y_nxt;
            laserexists <= exists_nxt;
            Ehit        <= ehit_nxt;
            score_inc   <= |ehit_nxt;
        end
    end

endmodule

// File: tb/tb_player_cannon.sv
// Self-checking bench for player_cannon: launch table, hand-written corner sequences, random frames vs model.
module tb_player_cannon;

    localparam int N = 4;

    logic          frame_clk = 1'b0;
    logic          Reset = 1'b1;
    logic          fire = 1'b0;
    logic [9:0]    PSX = '0, PSY = '0;
    logic [10*N-1:0] EX_all = '0, EY_all = '0;
    logic [N-1:0]  enemy_alive = '0;
    logic [9:0]    laserX, laserY;
    logic          laserexists;
    logic [N-1:0]  Ehit;
    logic          score_inc;

    int checks = 0;
    int errors = 0;

    player_cannon #(.N_ENEMY(N), .LASER_SPEED(8), .COOLDOWN_FRAMES(15)) dut (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .fire       (fire),
        .PSX        (PSX),
        .PSY        (PSY),
        .EX_all     (EX_all),
        .EY_all     (EY_all),
        .enemy_alive(enemy_alive),
        .laserX     (laserX),
        .laserY     (laserY),
        .laserexists(laserexists),
        .Ehit       (Ehit),
        .score_inc  (score_inc)
    );

    always #5 frame_clk = ~frame_clk;

    // Reference model: laser position, frames of lockout left, previous key level.
    bit       m_on;
    int       m_x, m_y, m_cool;
    bit       m_prev;
    logic [N-1:0] m_hit;

    function automatic bit boxes_touch(int lx, int ly, int ex, int ey);
        return (lx <= ex + 15) && (ex <= lx + 1) && (ly <= ey + 15) && (ey <= ly + 7);
    endfunction

    task automatic model_reset();
        m_on = 0; m_x = 0; m_y = 0; m_cool = 0; m_prev = 1; m_hit = '0;
    endtask

    task automatic model_edge();
        int hit_i;
        hit_i = -1;
        m_hit = '0;
        if (m_on) begin
            for (int i = N - 1; i >= 0; i--)
                if (enemy_alive[i] && boxes_touch(m_x, m_y, int'(EX_all[10*i +: 10]), int'(EY_all[10*i +: 10])))
                    hit_i = i;
            if (hit_i >= 0 || m_y < 16) begin
                if (hit_i >= 0) m_hit[hit_i] = 1'b1;
                m_on = 0; m_x = 0; m_y = 0; m_cool = 15;
            end else begin
                m_y = m_y - 8;
            end
        end else if (m_cool > 0) begin
            m_cool = m_cool - 1;
        end else if (fire && !m_prev) begin
            m_on = 1;
            m_x  = (int'(PSX) + 14) % 1024;
            m_y  = (PSY < 16) ? 8 : int'(PSY) - 8;
        end
        m_prev = fire;
    endtask

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge frame_clk);
        #1;
        check("frame", {6'd0, laserexists, laserX, laserY, Ehit, score_inc},
              {6'd0, m_on, 10'(m_x), 10'(m_y), m_hit, |m_hit});
    endtask

    // Called one time unit after a clock edge; pulse stays clear of the next edge.
    task automatic do_reset(bit f);
        fire = f;
        Reset = 1'b1;
        #1;
        check("reset_vals", {21'd0, laserexists, laserX, laserY, Ehit, score_inc}, 32'd0);
        model_reset();
        #1;
        Reset = 1'b0;
    endtask

    task automatic set_enemy(int i, int x, int y, bit a);
        EX_all[10*i +: 10] = 10'(x);
        EY_all[10*i +: 10] = 10'(y);
        enemy_alive[i]     = a;
    endtask

    task automatic fire_shot();
        fire = 1'b0; step();
        fire = 1'b1; step();
        fire = 1'b0;
    endtask

    typedef struct {
        logic [9:0] psx, psy, exp_x, exp_y;
    } launch_vec_t;

    launch_vec_t lv[8];
    int hit_edge, gone_edge;

    initial begin
        lv[0] = '{10'd300,  10'd440, 10'd314,  10'd432};
        lv[1] = '{10'd0,    10'd0,   10'd14,   10'd8};
        lv[2] = '{10'd100,  10'd16,  10'd114,  10'd8};
        lv[3] = '{10'd100,  10'd15,  10'd114,  10'd8};
        lv[4] = '{10'd50,   10'd17,  10'd64,   10'd9};
        lv[5] = '{10'd600,  10'd479, 10'd614,  10'd471};
        lv[6] = '{10'd1009, 10'd100, 10'd1023, 10'd92};
        lv[7] = '{10'd200,  10'd24,  10'd214,  10'd16};

        model_reset();
        #3;
        check("reset_vals", {21'd0, laserexists, laserX, laserY, Ehit, score_inc}, 32'd0);
        Reset = 1'b0;
        step();

        // Launch position table, all enemies dead.
        for (int k = 0; k < 8; k++) begin
            do_reset(1'b0);
            enemy_alive = '0;
            PSX = lv[k].psx; PSY = lv[k].psy;
            fire_shot();
            check("launch", {11'd0, laserexists, laserX, laserY}, {11'd0, 1'b1, lv[k].exp_x, lv[k].exp_y});
            step();
        end

        // Hit on enemy 0, with fire toggling during flight.
        do_reset(1'b0);
        PSX = 10'd300; PSY = 10'd440;
        set_enemy(0, 310, 200, 1); set_enemy(1, 0, 0, 0); set_enemy(2, 0, 0, 0); set_enemy(3, 0, 0, 0);
        fire_shot();
        hit_edge = -1;
        for (int k = 1; k <= 60; k++) begin
            fire = k[1];
            step();
            if (Ehit != '0) begin
                hit_edge = k;
                break;
            end
        end
        check("hit_edge", hit_edge, 29);
        check("hit_onehot", {27'd0, Ehit, score_inc, laserexists}, {27'd0, 4'b0001, 1'b1, 1'b0});
        fire = 1'b0;
        step();
        check("pulse_clear", {27'd0, Ehit, score_inc}, 32'd0);
        for (int k = 0; k < 13; k++) step();
        fire = 1'b1; step();   // last cooldown edge: ignored
        step();                // held: no edge
        check("no_early_shot", laserexists, 1'b0);
        fire = 1'b0; step();
        fire = 1'b1; step();
        check("refire", laserexists, 1'b1);
        fire = 1'b0;

        // Dead enemy: laser runs to the top.
        do_reset(1'b0);
        set_enemy(0, 310, 200, 0);
        fire_shot();
        gone_edge = -1;
        for (int k = 1; k <= 80; k++) begin
            step();
            if (k == 53) check("top_y8", laserY, 10'd8);
            if (Ehit != '0) check("dead_no_hit", Ehit, 4'b0000);
            if (!laserexists) begin
                gone_edge = k;
                break;
            end
        end
        check("top_edge", gone_edge, 54);
        for (int k = 0; k < 15; k++) step();
        fire = 1'b1; step();
        check("refire_exact", laserexists, 1'b1);
        fire = 1'b0;

        // Enemies 1 and 2 both overlap: lowest index wins.
        do_reset(1'b0);
        set_enemy(0, 500, 200, 0); set_enemy(1, 310, 200, 1); set_enemy(2, 305, 200, 1);
        fire_shot();
        hit_edge = -1;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (Ehit != '0) begin
                hit_edge = k;
                break;
            end
        end
        check("tie_edge", hit_edge, 29);
        check("tie_onehot", Ehit, 4'b0010);

        // Fire held through reset release.
        do_reset(1'b1);
        for (int k = 0; k < 5; k++) step();
        check("held_no_shot", laserexists, 1'b0);

        // Asynchronous reset mid-flight.
        fire = 1'b0;
        enemy_alive = '0;
        fire_shot();
        for (int k = 0; k < 29; k++) step();
        check("mid_y200", laserY, 10'd200);
        do_reset(1'b0);

        // Randomized frames against the model.
        for (int k = 0; k < 4000; k++) begin
            if (k % 64 == 0)
                for (int i = 0; i < N; i++)
                    set_enemy(i, 290 + $urandom_range(0, 40), $urandom_range(0, 470), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) fire = ~fire;
            PSX = 10'(280 + $urandom_range(0, 40));
            PSY = 10'($urandom_range(0, 479));
            if ($urandom_range(0, 499) == 0) do_reset(fire);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
